// File: rtl/t_frame_pkg.sv
// Shared definitions for the 8-lane transport framer/deframer pair.
// Holds the frame geometry, the alignment state type and the word field helpers.
package t_frame_pkg;
    localparam int NUM_LANES        = 8;
    localparam int OCTETS_PER_FRAME = 4;
    localparam int SAMPLE_W         = 12;
    localparam int TAIL_W           = 4;
    localparam int WORD_W           = 64;
    localparam int SAMPLES_PER_WORD = 4;
    localparam int WORDS_PER_FRAME  = NUM_LANES / 2;
    localparam int ADC_W            = SAMPLES_PER_WORD * SAMPLE_W;

    typedef enum logic {HUNT = 1'b0, SYNC = 1'b1} fsm_state_t;

    // Index 0 is the most significant sample (s0) so the packed samples field is {s0,s1,s2,s3}.
    typedef struct packed {
        logic [0:SAMPLES_PER_WORD-1][SAMPLE_W-1:0] samples;
        logic [0:SAMPLES_PER_WORD-1][TAIL_W-1:0]   tails;
    } word_fields_t;

    function automatic word_fields_t unpack_word(input logic [WORD_W-1:0] w);
        word_fields_t f;
        for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
            f.samples[i] = w[WORD_W-1-(SAMPLE_W+TAIL_W)*i -: SAMPLE_W];
            f.tails[i]   = w[WORD_W-1-SAMPLE_W-(SAMPLE_W+TAIL_W)*i -: TAIL_W];
        end
        return f;
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(input word_fields_t f);
        logic [WORD_W-1:0] w;
        for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
            w[WORD_W-1-(SAMPLE_W+TAIL_W)*i -: (SAMPLE_W+TAIL_W)] = {f.samples[i], f.tails[i]};
        end
        return w;
    endfunction
endpackage

// File: rtl/t_deframe_bank.sv
// One frame buffer of four 64-bit transport words.
// Written one octet position at a time across all lanes; read one word at a time.
module t_deframe_bank
    import t_frame_pkg::*;
(
    input  logic                            clk,
    input  logic                            wr_en,
    input  logic [1:0]                      wr_oct,
    input  logic [NUM_LANES-1:0][7:0]       wr_lanes,
    input  logic [1:0]                      rd_idx,
    output logic [WORD_W-1:0]               rd_word
);
    // Even lanes carry the upper half of each word, odd lanes the lower half.
    logic [7:0] hi [WORDS_PER_FRAME][OCTETS_PER_FRAME];
    logic [7:0] lo [WORDS_PER_FRAME][OCTETS_PER_FRAME];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < WORDS_PER_FRAME; j++) begin
                hi[j][wr_oct] <= wr_lanes[2*j];
                lo[j][wr_oct] <= wr_lanes[2*j+1];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < OCTETS_PER_FRAME; k++) begin
            rd_word[WORD_W-1-8*k -: 8]   = hi[rd_idx][k];
            rd_word[WORD_W/2-1-8*k -: 8] = lo[rd_idx][k];
        end
    end
endmodule

// File: rtl/t_deframe.sv
// Receive-side transport deframer: aligns 8-lane octet frames, ping-pong buffers them
// and streams one 48-bit ADC word per cycle with tail checking and error counting.
module t_deframe
    import t_frame_pkg::*;
#(
    parameter bit CHECK_TAIL = 1'b1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [7:0]           lane0,
    input  logic [7:0]           lane1,
    input  logic [7:0]           lane2,
    input  logic [7:0]           lane3,
    input  logic [7:0]           lane4,
    input  logic [7:0]           lane5,
    input  logic [7:0]           lane6,
    input  logic [7:0]           lane7,
    output logic [ADC_W-1:0]     adc_data,
    output logic                 adc_valid,
    output logic [TAIL_W-1:0]    tail_bits,
    output logic                 tail_err,
    output logic                 frame_err,
    output logic                 synced,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    logic [NUM_LANES-1:0][7:0] lanes;
    assign lanes = {lane7, lane6, lane5, lane4, lane3, lane2, lane1, lane0};

    fsm_state_t       state;
    logic [1:0]       oct_cnt;
    logic             fill_ptr;
    logic             drain_ptr;
    logic [1:0]       drain_idx;
    logic [1:0]       bank_rdy;

    logic             cap;
    logic [1:0]       cap_oct;
    logic             sof_err;
    logic             lost_err;
    logic             frame_err_nxt;

    // Capture decision for the octet on the lanes this cycle.
    always_comb begin
        cap      = 1'b0;
        cap_oct  = 2'd0;
        sof_err  = 1'b0;
        lost_err = 1'b0;
        if (in_valid) begin
            if (state == HUNT) begin
                cap = in_sof;
            end else if (in_sof) begin
                cap     = 1'b1;
                sof_err = (oct_cnt != 2'd0);
            end else if (oct_cnt == 2'd0) begin
                lost_err = 1'b1;
            end else begin
                cap     = 1'b1;
                cap_oct = oct_cnt;
            end
        end
    end
    assign frame_err_nxt = sof_err | lost_err;

    logic [WORD_W-1:0] rd_word0, rd_word1, rd_word;

    t_deframe_bank u_bank0 (
        .clk      (clk),
        .wr_en    (cap && !fill_ptr),
        .wr_oct   (cap_oct),
        .wr_lanes (lanes),
        .rd_idx   (drain_idx),
        .rd_word  (rd_word0)
    );

    t_deframe_bank u_bank1 (
        .clk      (clk),
        .wr_en    (cap && fill_ptr),
        .wr_oct   (cap_oct),
        .wr_lanes (lanes),
        .rd_idx   (drain_idx),
        .rd_word  (rd_word1)
    );

    assign rd_word = drain_ptr ? rd_word1 : rd_word0;

    word_fields_t     fields;
    logic             drain_go;
    logic             word_tail_err;
    logic [1:0]       err_inc;
    logic [ERR_CNT_W:0] err_sum;

    always_comb begin
        fields        = unpack_word(rd_word);
        drain_go      = bank_rdy[drain_ptr];
        word_tail_err = CHECK_TAIL && !((fields.tails[0] == fields.tails[1]) &&
                                        (fields.tails[1] == fields.tails[2]) &&
                                        (fields.tails[2] == fields.tails[3]));
        err_inc       = {1'b0, frame_err_nxt} + {1'b0, drain_go & word_tail_err};
        err_sum       = {1'b0, err_cnt} + {{(ERR_CNT_W-1){1'b0}}, err_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            oct_cnt   <= 2'd0;
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
            drain_idx <= 2'd0;
            bank_rdy  <= 2'b00;
            adc_data  <= '0;
            adc_valid <= 1'b0;
            tail_bits <= '0;
            tail_err  <= 1'b0;
            frame_err <= 1'b0;
            synced    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_err <= frame_err_nxt;
            err_cnt   <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];

            if (cap) oct_cnt <= cap_oct + 2'd1;
            if (state == HUNT && cap) begin
                state  <= SYNC;
                synced <= 1'b1;
            end
            if (lost_err) begin
                state  <= HUNT;
                synced <= 1'b0;
            end

            // Drain stage: one word per edge from the oldest ready bank.
            adc_valid <= drain_go;
            if (drain_go) begin
                adc_data  <= fields.samples;
                tail_bits <= fields.tails[0];
                tail_err  <= word_tail_err;
                drain_idx <= drain_idx + 2'd1;
                if (drain_idx == 2'd3) begin
                    bank_rdy[drain_ptr] <= 1'b0;
                    drain_ptr           <= ~drain_ptr;
                end
            end

            if (cap && cap_oct == 2'd3) begin
                bank_rdy[fill_ptr] <= 1'b1;
                fill_ptr           <= ~fill_ptr;
            end
        end
    end
endmodule

// File: tb/tb_t_deframe.sv
// Bench for t_deframe: directed and random frames checked against a frame-level model.
// A second instance with tail checking disabled runs on the same stimulus.
module tb_t_deframe;
    import t_frame_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic [7:0] lane_d [8];

    logic [47:0] adc_data_a, adc_data_b;
    logic        adc_valid_a, adc_valid_b;
    logic [3:0]  tail_bits_a, tail_bits_b;
    logic        tail_err_a, tail_err_b;
    logic        frame_err_a, frame_err_b;
    logic        synced_a, synced_b;
    logic [7:0]  err_cnt_a, err_cnt_b;

    always #5 clk = ~clk;

    t_deframe dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .lane0(lane_d[0]), .lane1(lane_d[1]), .lane2(lane_d[2]), .lane3(lane_d[3]),
        .lane4(lane_d[4]), .lane5(lane_d[5]), .lane6(lane_d[6]), .lane7(lane_d[7]),
        .adc_data(adc_data_a), .adc_valid(adc_valid_a), .tail_bits(tail_bits_a),
        .tail_err(tail_err_a), .frame_err(frame_err_a), .synced(synced_a), .err_cnt(err_cnt_a)
    );

    t_deframe #(.CHECK_TAIL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .lane0(lane_d[0]), .lane1(lane_d[1]), .lane2(lane_d[2]), .lane3(lane_d[3]),
        .lane4(lane_d[4]), .lane5(lane_d[5]), .lane6(lane_d[6]), .lane7(lane_d[7]),
        .adc_data(adc_data_b), .adc_valid(adc_valid_b), .tail_bits(tail_bits_b),
        .tail_err(tail_err_b), .frame_err(frame_err_b), .synced(synced_b), .err_cnt(err_cnt_b)
    );

    typedef struct {
        logic [47:0] data;
        logic [3:0]  tb;
        logic        te;
        int          cyc;
    } obs_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    obs_t rx_q[$];
    obs_t rxb_q[$];
    obs_t exp_q[$];

    bit          m_synced = 1'b0;
    logic [63:0] m_oct_q[$];
    int          m_ferr = 0;
    int          m_terr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        obs_t o;
        @(posedge clk);
        #1;
        cyc++;
        if (adc_valid_a) begin
            o.data = adc_data_a; o.tb = tail_bits_a; o.te = tail_err_a; o.cyc = cyc;
            rx_q.push_back(o);
        end
        if (adc_valid_b) begin
            o.data = adc_data_b; o.tb = tail_bits_b; o.te = tail_err_b; o.cyc = cyc;
            rxb_q.push_back(o);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [63:0] frame_octet(input logic [3:0][63:0] w, input int k);
        logic [63:0] v;
        for (int j = 0; j < 4; j++) begin
            v[16*j +: 8]   = w[j][63-8*k -: 8];
            v[16*j+8 +: 8] = w[j][31-8*k -: 8];
        end
        return v;
    endfunction

    function automatic logic [63:0] rand_word(input bit bad_tail);
        logic [3:0]  t;
        logic [3:0]  tt [4];
        logic [11:0] s [4];
        t = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            tt[i] = t;
            s[i]  = 12'($urandom);
        end
        if (bad_tail) tt[$urandom_range(0, 3)] = t ^ 4'($urandom_range(1, 15));
        return {s[0], tt[0], s[1], tt[1], s[2], tt[2], s[3], tt[3]};
    endfunction

    // A complete frame seen at edge e yields its four words on edges e+1..e+4.
    task automatic emit(input int e);
        logic [63:0] w;
        obs_t o;
        for (int j = 0; j < 4; j++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                w[63-8*k -: 8] = m_oct_q[k][16*j +: 8];
                w[31-8*k -: 8] = m_oct_q[k][16*j+8 +: 8];
            end
            o.data = {w[63:52], w[47:36], w[31:20], w[15:4]};
            o.tb   = w[51:48];
            o.te   = !((w[51:48] == w[35:32]) && (w[35:32] == w[19:16]) && (w[19:16] == w[3:0]));
            o.cyc  = e + 1 + j;
            exp_q.push_back(o);
            if (o.te) m_terr++;
        end
    endtask

    task automatic send_octet(input bit sof, input logic [63:0] v);
        bit ferr;
        ferr = 1'b0;
        in_valid = 1'b1;
        in_sof = sof;
        for (int i = 0; i < 8; i++) lane_d[i] = v[8*i +: 8];
        if (!m_synced) begin
            if (sof) begin
                m_synced = 1'b1;
                m_oct_q = {v};
            end
        end else if (sof) begin
            if (m_oct_q.size() != 0) ferr = 1'b1;
            m_oct_q = {v};
        end else if (m_oct_q.size() == 0) begin
            ferr = 1'b1;
            m_synced = 1'b0;
        end else begin
            m_oct_q.push_back(v);
        end
        tick();
        in_valid = 1'b0;
        in_sof = 1'b0;
        if (ferr) m_ferr++;
        if (m_oct_q.size() == 4) begin
            emit(cyc);
            m_oct_q.delete();
        end
        check("frame_err", 64'(frame_err_a), 64'(ferr));
        check("synced", 64'(synced_a), 64'(m_synced));
    endtask

    task automatic send_frame(input logic [3:0][63:0] w, input int gap_pos, input int gap_len);
        for (int k = 0; k < 4; k++) begin
            if (k == gap_pos) idle(gap_len);
            send_octet(k == 0, frame_octet(w, k));
        end
    endtask

    task automatic compare_all();
        int n;
        int ea;
        check("rx_count", 64'(rx_q.size()), 64'(exp_q.size()));
        check("rxb_count", 64'(rxb_q.size()), 64'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("adc_data", 64'(rx_q[i].data), 64'(exp_q[i].data));
            check("tail_bits", 64'(rx_q[i].tb), 64'(exp_q[i].tb));
            check("tail_err", 64'(rx_q[i].te), 64'(exp_q[i].te));
            check("word_cycle", 64'(rx_q[i].cyc), 64'(exp_q[i].cyc));
        end
        n = (rxb_q.size() < exp_q.size()) ? rxb_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("adc_data_nocheck", 64'(rxb_q[i].data), 64'(exp_q[i].data));
            check("tail_err_nocheck", 64'(rxb_q[i].te), 64'd0);
        end
        ea = m_ferr + m_terr;
        if (ea > 255) ea = 255;
        check("err_cnt", 64'(err_cnt_a), 64'(ea));
        check("err_cnt_nocheck", 64'(err_cnt_b), 64'((m_ferr > 255) ? 255 : m_ferr));
        rx_q.delete();
        rxb_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [3:0][63:0] w;
        int mode;

        for (int i = 0; i < 8; i++) lane_d[i] = 8'h00;

        // Reset state
        idle(2);
        check("rst_adc_data", 64'(adc_data_a), 64'd0);
        check("rst_adc_valid", 64'(adc_valid_a), 64'd0);
        check("rst_synced", 64'(synced_a), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_a), 64'd0);
        check("rst_frame_err", 64'(frame_err_a), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Single known frame
        for (int j = 0; j < 4; j++) w[j] = 64'h1235_4565_7895_ABC5;
        send_frame(w, 4, 0);
        idle(6);
        if (rx_q.size() > 0) begin
            check("known_data", 64'(rx_q[0].data), 64'h1234_5678_9ABC);
            check("known_tail", 64'(rx_q[0].tb), 64'h5);
        end
        compare_all();

        // Three back-to-back frames
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 4; j++) w[j] = rand_word(1'b0);
            send_frame(w, 4, 0);
        end
        idle(6);
        compare_all();

        // Known frame with a 2-cycle gap between octets 1 and 2
        for (int j = 0; j < 4; j++) w[j] = 64'h1235_4565_7895_ABC5;
        send_frame(w, 2, 2);
        idle(6);
        if (rx_q.size() > 0) check("gap_data", 64'(rx_q[0].data), 64'h1234_5678_9ABC);
        compare_all();

        // Early sof restarts the frame, then a non-sof at octet 0 drops sync
        for (int j = 0; j < 4; j++) w[j] = rand_word(1'b0);
        send_octet(1'b1, frame_octet(w, 0));
        send_octet(1'b0, frame_octet(w, 1));
        for (int j = 0; j < 4; j++) w[j] = rand_word(1'b0);
        send_frame(w, 4, 0);
        idle(6);
        check("early_sof_err_cnt", 64'(err_cnt_a), 64'd1);
        compare_all();
        send_octet(1'b0, {$urandom, $urandom});
        check("lost_sync_err_cnt", 64'(err_cnt_a), 64'd2);
        send_octet(1'b0, {$urandom, $urandom});
        for (int j = 0; j < 4; j++) w[j] = rand_word(1'b0);
        send_frame(w, 4, 0);
        idle(6);
        compare_all();

        // Tails 5,5,5,6 on word 2 only
        for (int j = 0; j < 4; j++) w[j] = rand_word(1'b0);
        w[2] = {12'h321, 4'h5, 12'h654, 4'h5, 12'h987, 4'h5, 12'hCBA, 4'h6};
        send_frame(w, 4, 0);
        idle(6);
        compare_all();

        // Random frames with gaps, bad tails, aborted frames and stray octets
        for (int f = 0; f < 30; f++) begin
            for (int j = 0; j < 4; j++) w[j] = rand_word($urandom_range(0, 4) == 0);
            mode = $urandom_range(0, 9);
            if (mode == 1) send_octet(1'b0, {$urandom, $urandom});
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send_octet(k == 0, frame_octet(w, k));
                if (mode == 0 && k == 1) break;
            end
        end
        idle(8);
        compare_all();

        // Reset in the middle of a drain
        for (int j = 0; j < 4; j++) w[j] = rand_word(1'b0);
        send_frame(w, 4, 0);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_adc_valid", 64'(adc_valid_a), 64'd0);
        check("mid_rst_synced", 64'(synced_a), 64'd0);
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        m_synced = 1'b0;
        m_oct_q.delete();
        m_ferr = 0;
        m_terr = 0;
        idle(2);
        rst_n = 1'b1;
        idle(6);
        compare_all();

        for (int j = 0; j < 4; j++) w[j] = rand_word(1'b1);
        send_frame(w, 4, 0);
        idle(6);
        compare_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/t_deframe.md
Name: t_deframe

Overview:
- Receive-side transport deframer. It is the inverse of the 8-lane transport framer.
- Accepts 8 byte-lanes of 4-octet frames and rebuilds four 64-bit transport words per frame.
- Strips the 4-bit tail nibble from each 16-bit sample container and streams one 48-bit ADC word (4 x 12-bit samples) per cycle to the downstream sample path.
- Includes frame alignment, tail-bit checking and error counting.

Parameters:
- CHECK_TAIL, 1, 1 = compare the four tail nibbles of each word and flag disagreement; 0 = tail_err tied low.
- ERR_CNT_W, 8, width of the saturating frame/tail error counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  lane octets valid this cycle
- in_sof  input  1  qualifies octet 0 of a frame (meaningful only with in_valid)
- lane0..lane7  input  8 each  lane octets
- adc_data  output  48  {s0,s1,s2,s3}, 12 bits each, s0 in [47:36]
- adc_valid  output  1  adc_data/tail_bits/tail_err valid
- tail_bits  output  4  tail nibble of sample s0 of the current word
- tail_err  output  1  tail nibbles within the current word disagree
- frame_err  output  1  one-cycle pulse on an alignment error
- synced  output  1  aligned to frame boundaries
- err_cnt  output  ERR_CNT_W  saturating count of frame_err plus tail_err events

Behaviour:
- Reset: all outputs 0, both banks empty, state HUNT, octet counter 0. Reset asserted mid-operation discards all partial and ready data immediately.
- Frame mapping (frame octet k = 0..3, word j = 0..3):
  - lane(2j) octet k = word_j[63-8k -: 8]
  - lane(2j+1) octet k = word_j[31-8k -: 8]
  - word_j = {s0,t0,s1,t1,s2,t2,s3,t3}, each sample 12 bits followed by its 4-bit tail.
- Alignment FSM:
  - HUNT: ignore octets until in_valid & in_sof. That octet is captured as octet 0, synced<=1, go to SYNC.
  - SYNC: each in_valid octet advances the counter 0..3 and wraps.
    - in_sof with counter != 0: frame_err pulse, partial bank discarded, this octet captured as octet 0 of a new frame; stay in SYNC.
    - in_valid without in_sof at counter == 0: frame_err pulse, synced<=0, go to HUNT, octet dropped.
  - in_valid low: counter holds. Gaps are allowed anywhere in a frame.
- Buffering (ping-pong):
  - Two banks of 4 x 64 bits. Capture alternates banks per completed frame.
  - The octet-3 capture edge marks the fill bank ready and switches the fill pointer.
- Drain:
  - Starts at the edge after a bank becomes ready.
  - On 4 consecutive edges, registers word0..word3 onto adc_data with adc_valid = 1. Bank freed after word3.
  - Latency: octet-3 capture edge E, then word0 registered at E+1 and word3 at E+4.
  - No backpressure exists. With at most 1 octet/cycle input, a bank always drains before the other bank completes, so overflow is impossible.
  - Continuous input yields continuous adc_valid.
  - adc_valid = 0 when idle. adc_data holds its last value when not valid.
- Tail handling:
  - tail_bits = t0 of the output word.
  - tail_err = CHECK_TAIL & ~(t0==t1==t2==t3), registered with the word, valid only with adc_valid.
- err_cnt:
  - +1 per frame_err pulse, +1 per word with tail_err; +2 if both occur in the same cycle.
  - Saturates at all-ones. Cleared only by reset.

Decomposition:
- Shared package t_frame_pkg:
  - constants NUM_LANES=8, OCTETS_PER_FRAME=4, SAMPLE_W=12, TAIL_W=4, WORD_W=64
  - FSM state enum {HUNT, SYNC}
  - a function pack/unpack between 64-bit word and {samples, tails}, shared with the framer.
- One sub-module t_deframe_bank: single 4x64 bank with a per-octet lane write port and a word read port, instantiated twice.

Test Plan:
- Reset -> adc_data 0, adc_valid 0, synced 0, err_cnt 0; assert rst_n mid-drain -> adc_valid drops to 0 immediately, no further words.
- One frame; all four words = 0x1235_4565_7895_ABC5:
  - lane(2j) octets 0x12,0x35,0x45,0x65; lane(2j+1) octets 0x78,0x95,0xAB,0xC5.
  - -> 4 cycles of adc_data 0x123456789ABC, tail_bits 0x5, tail_err 0, word0 at E+1.
- 3 back-to-back frames with distinct words -> adc_valid high 12 consecutive cycles, words in order j=0..3 per frame, no loss.
- Same frame with in_valid low for 2 cycles between octets 1 and 2 -> identical output, delayed by 2 cycles.
- in_sof at octet 2 -> frame_err pulse, err_cnt=1, partial frame never output, following frame from that sof output correctly; non-sof octet at counter 0 -> synced=0, HUNT, err_cnt=2.
- Word with tails 5,5,5,6 -> tail_err=1 on that word only, err_cnt increments; CHECK_TAIL=0 -> tail_err 0, no increment.
